// File: rtl/sliced_add_sequencer.sv
// rtl/sliced_add_sequencer.sv - multi-cycle adder/subtractor, one CLA slice per cycle, LSB slice first.
// Optional macro SLICED_ADD_OVF_EN builds signed-overflow capture; otherwise ovf is tied low.
module sliced_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             zero,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // 4-bit carry-lookahead group: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g = x & y;
    p = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Groups are chained inside the slice; returns {carry_out, slice_sum}.
  function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x, input logic [SLICE-1:0] y,
                                               input logic cin);
    logic [SLICE:0] r;
    logic [4:0]     grp;
    logic           c;
    r = '0;
    c = cin;
    for (int i = 0; i < SLICE / 4; i++) begin
      grp        = cla4(x[4*i +: 4], y[4*i +: 4], c);
      r[4*i +: 4] = grp[3:0];
      c          = grp[4];
    end
    r[SLICE] = c;
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             zero_q, zero_d;
  logic [SLICE:0]   slice_res;

  always_comb begin
    slice_res = slice_add(a_q[int'(k_q)*SLICE +: SLICE], b_q[int'(k_q)*SLICE +: SLICE], carry_q);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{op_sub}};
          carry_d = op_sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(k_q)*SLICE +: SLICE] = slice_res[SLICE-1:0];
        carry_d = slice_res[SLICE];
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          c_out_d = slice_res[SLICE];
          zero_d  = (sum_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      zero_q  <= zero_d;
    end
  end

`ifdef SLICED_ADD_OVF_EN
  logic ovf_q, ovf_d;

  // Carry into the MSB is recovered as a^b^sum at that bit.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && k_q == K_LAST) begin
      ovf_d = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_d[WIDTH-1] ^ slice_res[SLICE];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign zero      = zero_q;

endmodule
